// File: rtl/ysyx_ifu_pkg.sv
// ysyx_ifu_pkg: shared instruction-fetch types and constants
package ysyx_ifu_pkg;
    localparam int IFU_XLEN = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} ifu_state_e;
endpackage

// File: rtl/ysyx_ifu_if.sv
// ysyx_ifu_if: instruction-memory req/rsp port plus downstream instruction handoff
interface ysyx_ifu_if import ysyx_ifu_pkg::*; #(parameter int XLEN = IFU_XLEN);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/ysyx_ifu.sv
// ysyx_ifu: single-outstanding instruction fetch with redirect and stale-response dropping
module ysyx_ifu import ysyx_ifu_pkg::*; #(
    parameter int XLEN = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    ysyx_ifu_if.master       bus,
    output logic [31:0]      fetch_cnt
);
    ifu_state_e state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n, inst_buf, inst_n, pc_buf, pc_n;
    logic [31:0] cnt_n;
    logic drop, drop_n;
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_req_addr = fetch_pc;
    assign bus.inst_valid = state == HOLD;
    assign bus.inst = inst_buf;
    assign bus.pc = pc_buf;
    always_comb begin
        state_n = state;
        fetch_pc_n = fetch_pc;
        drop_n = drop;
        inst_n = inst_buf;
        pc_n = pc_buf;
        cnt_n = fetch_cnt;
        unique case (state)
            IDLE: state_n = REQ;
            REQ:  state_n = bus.imem_req_ready ? WAIT : REQ;
            WAIT: if (bus.imem_rsp_valid) begin
                state_n = drop ? REQ : HOLD;
                drop_n = 1'b0;
                inst_n = drop ? inst_buf : bus.imem_rsp_data;
                pc_n = drop ? pc_buf : fetch_pc;
            end
            HOLD: if (bus.inst_ready) begin
                state_n = REQ;
                fetch_pc_n = pc_buf + XLEN'(4);
                cnt_n = fetch_cnt + 32'd1;
            end
        endcase
        // A redirect overrides the PC; an in-flight request is marked to be dropped on return.
        if (redirect_valid) begin
            fetch_pc_n = {redirect_pc[XLEN-1:2], 2'b00};
            drop_n = (state == REQ && bus.imem_req_ready) || (state == WAIT && !bus.imem_rsp_valid);
            state_n = (state == HOLD || (state == WAIT && bus.imem_rsp_valid)) ? REQ : state_n;
            inst_n = inst_buf;
            pc_n = pc_buf;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            drop <= 1'b0;
            inst_buf <= '0;
            pc_buf <= '0;
            fetch_cnt <= '0;
        end else begin
            state <= state_n;
            fetch_pc <= fetch_pc_n;
            drop <= drop_n;
            inst_buf <= inst_n;
            pc_buf <= pc_n;
            fetch_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_ysyx_ifu.sv
// tb_ysyx_ifu: randomized fetch/redirect/reset stimulus checked by a scoreboard of redirect events
module tb_ysyx_ifu;
    import ysyx_ifu_pkg::*;
    localparam logic [31:0] RPC = 32'h8000_0000;
    typedef struct { int cyc; bit is_rst; logic [31:0] tgt; } ev_t;
    logic clk = 0;
    logic rst = 1;
    logic redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] fetch_cnt;
    int cyc = 0, errors = 0, checks = 0, delivered = 0;
    int lat_min = 1, lat_max = 1, rdy_pct = 100;
    ev_t ev_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] dlv_log[$];

    ysyx_ifu_if ifc();
    ysyx_ifu dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus(ifc.master),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // which: 0 = request about to be accepted, 1 = inst_valid, 2 = rsp_valid
    task automatic wait_sig(input int which, input string name);
        for (int i = 0; i < 200; i++) begin
            if (which == 0 && ifc.imem_req_valid && ifc.imem_req_ready) return;
            if (which == 1 && ifc.inst_valid) return;
            if (which == 2 && ifc.imem_rsp_valid) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_dlv(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            if (dlv_log.size() >= n) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1;
        redirect_pc = a;
        ev_q.push_back('{cyc: cyc, is_rst: 1'b0, tgt: a});
        tick();
        redirect_valid = 0;
    endtask

    // Memory model: one response per accepted request after a random latency; cleared by rst.
    initial begin
        logic acc_s, rsp_s, rst_s, pend;
        logic [31:0] a_s, paddr;
        int wcnt;
        pend = 0;
        paddr = 0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            rst_s = rst;
            acc_s = ifc.imem_req_valid && ifc.imem_req_ready;
            a_s = ifc.imem_req_addr;
            rsp_s = ifc.imem_rsp_valid;
            @(posedge clk);
            #1;
            if (rst_s) pend = 0;
            else begin
                if (rsp_s) pend = 0;
                if (acc_s === 1'b1) begin
                    chk("one_outstanding", {31'b0, pend}, 32'd0);
                    pend = 1;
                    paddr = a_s;
                    wcnt = $urandom_range(lat_max, lat_min) - 1;
                    acc_log.push_back(a_s);
                end else if (pend && wcnt > 0) wcnt--;
            end
            ifc.imem_rsp_valid = pend && wcnt == 0;
            ifc.imem_rsp_data = (pend && wcnt == 0) ? memf(paddr) : $urandom;
            ifc.imem_req_ready = $urandom_range(99, 0) < rdy_pct;
        end
    end

    // Monitor: expected stream is RESET_PC, +4 per delivery, retargeted by redirects, restarted by rst.
    initial begin
        logic [31:0] exp_pc, exp_cnt, rt;
        bit r, rd;
        exp_pc = RPC;
        exp_cnt = 0;
        rt = 0;
        forever begin
            @(negedge clk);
            r = 0;
            rd = 0;
            while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                if (ev_q[0].is_rst) r = 1;
                else begin
                    rd = 1;
                    rt = ev_q[0].tgt;
                end
                void'(ev_q.pop_front());
            end
            if (!r && ifc.inst_valid === 1'b1 && ifc.inst_ready === 1'b1) begin
                chk("deliver_pc", ifc.pc, exp_pc);
                chk("deliver_inst", ifc.inst, memf(exp_pc));
                chk("deliver_cnt", fetch_cnt, exp_cnt);
                dlv_log.push_back(ifc.pc);
                delivered++;
                exp_pc += 32'd4;
                exp_cnt += 32'd1;
            end
            if (r) begin
                exp_pc = RPC;
                exp_cnt = 0;
            end else if (rd) exp_pc = {rt[31:2], 2'b00};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] p, i0, c;
        int n, n0;
        ifc.imem_req_ready = 0;
        ifc.imem_rsp_valid = 0;
        ifc.imem_rsp_data = 0;
        ifc.inst_ready = 1;
        repeat (3) tick();
        chk("rst_req_valid", {31'b0, ifc.imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, ifc.inst_valid}, 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_pc", ifc.pc, 32'd0);
        chk("rst_inst", ifc.inst, 32'd0);
        acc_log.delete();
        rst = 0;
        tick();
        chk("first_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
        chk("first_req_addr", ifc.imem_req_addr, RPC);
        n = 0;
        for (int k = 0; k < 9; k++) begin
            n += int'(ifc.inst_valid);
            tick();
        end
        chk("valid_every_3rd", n, 32'd3);
        chk("cnt_after_3", fetch_cnt, 32'd3);
        chk("req_addr_0", acc_log.size() > 0 ? acc_log[0] : 32'hx, RPC);
        chk("req_addr_1", acc_log.size() > 1 ? acc_log[1] : 32'hx, RPC + 4);
        chk("req_addr_2", acc_log.size() > 2 ? acc_log[2] : 32'hx, RPC + 8);

        ifc.inst_ready = 0;
        wait_sig(1, "bp_wait_valid");
        p = ifc.pc;
        i0 = ifc.inst;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_pc_stable", ifc.pc, p);
            chk("bp_inst_stable", ifc.inst, i0);
            chk("bp_valid_noreq", {30'b0, ifc.inst_valid, ifc.imem_req_valid}, 32'd2);
        end
        ifc.inst_ready = 1;
        tick();
        wait_sig(0, "bp_next_req");
        chk("bp_next_addr", ifc.imem_req_addr, p + 4);

        lat_min = 4;
        lat_max = 4;
        wait_sig(0, "wait_redir_req");
        tick();
        dlv_log.delete();
        do_redirect(32'h8000_0100);
        wait_sig(0, "wait_redir_next");
        chk("wait_redir_no_stale", dlv_log.size(), 32'd0);
        chk("wait_redir_addr", ifc.imem_req_addr, 32'h8000_0100);
        wait_dlv(1, "wait_redir_dlv");
        chk("wait_redir_pc", dlv_log.size() > 0 ? dlv_log[0] : 32'hx, 32'h8000_0100);

        lat_min = 1;
        lat_max = 1;
        ifc.inst_ready = 0;
        wait_sig(1, "hold_redir_valid");
        c = fetch_cnt;
        ifc.inst_ready = 1;
        do_redirect(32'h8000_0203);
        chk("hold_redir_cnt", fetch_cnt, c + 1);
        chk("hold_redir_req", {31'b0, ifc.imem_req_valid}, 32'd1);
        chk("hold_redir_addr", ifc.imem_req_addr, 32'h8000_0200);

        lat_min = 2;
        lat_max = 2;
        wait_sig(0, "dbl_req");
        dlv_log.delete();
        do_redirect(32'h8000_0400);
        wait_sig(2, "dbl_stale_rsp");
        tick();
        wait_sig(2, "dbl_t1_rsp");
        do_redirect(32'h8000_0500);
        wait_dlv(1, "dbl_dlv");
        chk("dbl_first_pc", dlv_log.size() > 0 ? dlv_log[0] : 32'hx, 32'h8000_0500);

        lat_min = 4;
        lat_max = 4;
        wait_sig(0, "rst_mid_req");
        tick();
        rst = 1;
        ev_q.push_back('{cyc: cyc, is_rst: 1'b1, tgt: 32'h0});
        tick();
        chk("rst_mid_valids", {30'b0, ifc.inst_valid, ifc.imem_req_valid}, 32'd0);
        chk("rst_mid_cnt", fetch_cnt, 32'd0);
        rst = 0;
        wait_sig(0, "rst_mid_restart");
        chk("rst_mid_addr", ifc.imem_req_addr, RPC);

        lat_min = 1;
        lat_max = 1;
        ifc.inst_ready = 0;
        dlv_log.delete();
        do_redirect(32'hFFFF_FFFC);
        ifc.inst_ready = 1;
        wait_dlv(2, "wrap_dlv");
        chk("wrap_pc0", dlv_log.size() > 0 ? dlv_log[0] : 32'hx, 32'hFFFF_FFFC);
        chk("wrap_pc1", dlv_log.size() > 1 ? dlv_log[1] : 32'hx, 32'h0000_0000);

        lat_min = 1;
        lat_max = 4;
        rdy_pct = 60;
        n0 = delivered;
        for (int k = 0; k < 3000; k++) begin
            ifc.inst_ready = $urandom_range(99, 0) < 70;
            rst = $urandom_range(999, 0) < 3;
            redirect_valid = 0;
            if (rst) ev_q.push_back('{cyc: cyc, is_rst: 1'b1, tgt: 32'h0});
            else if ($urandom_range(99, 0) < 5) begin
                redirect_valid = 1;
                redirect_pc = $urandom;
                ev_q.push_back('{cyc: cyc, is_rst: 1'b0, tgt: redirect_pc});
            end
            tick();
        end
        rst = 0;
        redirect_valid = 0;
        ifc.inst_ready = 1;
        repeat (20) tick();
        chk("random_progress", {31'b0, (delivered - n0) > 100}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
